zcr_multi: RTL and testbench
============================

// Module: zcr_multi
// PURPOSE
//   Multi-channel zero-crossing-rate extractor with hysteresis. Counts sign changes of
//   N_CH parallel signed sample streams over fixed epochs of EPOCH_LENGTH samples and
//   presents one count per channel through a valid/ready output register. Sits between
//   the per-channel filter bank and the feature packer in the feature_extraction chain.
// PARAMETERS
//   N_CH          4     number of channels sampled in parallel
//   DATA_W        16    signed sample width per channel
//   EPOCH_LENGTH  256   samples per epoch (>= 2)
//   HYST          0     dead-band half-width; 0 <= HYST < 2**(DATA_W-1)
//   CNT_W         $clog2(EPOCH_LENGTH+1)   derived, width of each count
// PORTS
//   clk       in   1             clock, rising edge
//   rst_n     in   1             asynchronous active-low reset
//   en        in   1             synchronous enable; low = soft clear of accumulation
//   s_valid   in   1             sample vector valid (no backpressure, always accepted)
//   s_data    in   N_CH*DATA_W   ch k at [k*DATA_W +: DATA_W], two's complement
//   m_valid   out  1             epoch result available
//   m_ready   in   1             consumer accepts result when m_valid & m_ready
//   m_data    out  N_CH*CNT_W    ch k count at [k*CNT_W +: CNT_W]
//   overrun   out  1             1-cycle pulse: unread result overwritten
// BEHAVIOUR
//   Reset (rst_n low, async): m_valid=0, m_data=0, overrun=0, sample index=0, all
//   counts=0, all channel states=UNKNOWN.
//   Per-channel state {UNKNOWN, POS, NEG}, updated on each accepted sample (s_valid & en):
//   - x > +HYST -> POS; x < -HYST -> NEG; -HYST <= x <= +HYST -> state held.
//   - Crossing counted when state changes POS->NEG or NEG->POS; UNKNOWN->POS/NEG not
//     counted. With HYST=0, x==0 holds state.
//   - Channel state carries across epoch boundaries, so a crossing on sample 0 of an
//     epoch counts; max count per epoch = EPOCH_LENGTH (hence CNT_W).
//   Epoch framing: sample index 0..EPOCH_LENGTH-1, increments per accepted sample,
//   wraps to 0 after EPOCH_LENGTH-1. s_valid low = stall, nothing changes.
//   Result: on the edge accepting sample EPOCH_LENGTH-1, m_data <= counts including that
//   sample's crossings, m_valid <= 1, counts <= 0 (same edge). Latency 1 cycle.
//   Handshake: m_valid/m_data held stable until m_valid & m_ready; then m_valid <= 0.
//   - New result on same edge as handshake: m_valid stays 1, m_data = new, no overrun.
//   - New result while m_valid=1 and m_ready=0: m_data overwritten, overrun=1 for 1 cycle.
//   en low: index, counts, states -> 0/UNKNOWN each cycle; samples ignored; m_valid,
//   m_data, handshake unaffected (pending result still drained). Partial epoch discarded.
//   Reset mid-epoch or mid-handshake: all state to reset values immediately, no output.
//   Arithmetic: signed compare of DATA_W sample against HYST sign-extended; counters
//   CNT_W unsigned, cannot overflow by construction.
// TESTING
//   1 N_CH=4,L=8,HYST=0: ch0 alt +5/-5, ch1 const +3, ch2 all 0, ch3 -1,+1,+1.. ->
//     m_data={ch0 7, ch1 0, ch2 0, ch3 1}, m_valid 1 cycle after 8th sample.
//   2 HYST=10: ch0 seq +20,+5,-5,+3,-15,-2,+11,+9 -> count 2 (band samples ignored).
//   3 Continuity: epoch1 ends POS, epoch2 sample0 = -20 -> epoch2 count includes it (=1
//     for otherwise negative epoch).
//   4 m_ready=0 for two epochs -> overrun pulse at 2nd completion, m_data = 2nd result;
//     then m_ready=1 -> single accept, m_valid drops; accept same edge as new result ->
//     no overrun, m_valid stays 1.
//   5 s_valid gaps (random 50% duty) -> counts identical to gap-free run.
//   6 en low at sample 5 of 8, then high -> partial dropped, next epoch starts from
//     UNKNOWN; rst_n low mid-handshake -> m_valid=0, m_data=0 asynchronously.

Source files
------------

// File: rtl/zcr_multi.sv
// Multi-channel zero-crossing-rate extractor with hysteresis dead-band.
// Counts per-channel sign changes over fixed epochs and presents the counts through a valid/ready register.
//
//   state   | meaning
//   UNKNOWN | no sample outside the dead-band seen since reset/soft clear
//   POS     | last out-of-band sample was above +HYST
//   NEG     | last out-of-band sample was below -HYST
module zcr_multi #(
  parameter int N_CH         = 4,
  parameter int DATA_W       = 16,
  parameter int EPOCH_LENGTH = 256,
  parameter int HYST         = 0,
  localparam int CNT_W       = $clog2(EPOCH_LENGTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    s_valid,
  input  logic [N_CH*DATA_W-1:0]  s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [N_CH*CNT_W-1:0]   m_data,
  output logic                    overrun
);

  localparam int IDX_W = $clog2(EPOCH_LENGTH);
  localparam logic signed [DATA_W-1:0] C_HYST  = DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] C_NHYST = -C_HYST;

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'd0,
    ST_POS     = 2'd1,
    ST_NEG     = 2'd2
  } zc_state_t;

  zc_state_t                r_state     [N_CH];
  zc_state_t                w_state_nxt [N_CH];
  logic                     w_cross     [N_CH];
  logic signed [DATA_W-1:0] w_x         [N_CH];
  logic [CNT_W-1:0]         r_cnt       [N_CH];
  logic [CNT_W-1:0]         w_cnt_inc   [N_CH];
  logic [N_CH*CNT_W-1:0]    w_cnt_pack;
  logic [IDX_W-1:0]         r_idx;
  logic                     w_acc;
  logic                     w_last;
  logic                     r_m_valid;
  logic [N_CH*CNT_W-1:0]    r_m_data;
  logic                     r_overrun;

  assign w_acc  = s_valid & en;
  assign w_last = w_acc && (r_idx == IDX_W'(EPOCH_LENGTH - 1));

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign w_x[k] = $signed(s_data[k*DATA_W +: DATA_W]);
  end

  // Channel state register; en low is a soft clear back to UNKNOWN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) r_state[k] <= ST_UNKNOWN;
    end else if (!en) begin
      for (int k = 0; k < N_CH; k++) r_state[k] <= ST_UNKNOWN;
    end else if (s_valid) begin
      for (int k = 0; k < N_CH; k++) r_state[k] <= w_state_nxt[k];
    end
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      w_state_nxt[k] = r_state[k];
      if (w_x[k] > C_HYST)
        w_state_nxt[k] = ST_POS;
      else if (w_x[k] < C_NHYST)
        w_state_nxt[k] = ST_NEG;
    end
  end

  // UNKNOWN -> POS/NEG is the first polarity, not a crossing.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      w_cross[k] = ((r_state[k] == ST_POS) && (w_state_nxt[k] == ST_NEG)) ||
                   ((r_state[k] == ST_NEG) && (w_state_nxt[k] == ST_POS));
    end
  end

  always_comb begin
    w_cnt_pack = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_cnt_inc[k] = r_cnt[k] + CNT_W'(w_cross[k]);
      w_cnt_pack[k*CNT_W +: CNT_W] = w_cnt_inc[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      for (int k = 0; k < N_CH; k++) r_cnt[k] <= '0;
    end else if (!en) begin
      r_idx <= '0;
      for (int k = 0; k < N_CH; k++) r_cnt[k] <= '0;
    end else if (w_acc) begin
      r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      for (int k = 0; k < N_CH; k++) r_cnt[k] <= w_last ? '0 : w_cnt_inc[k];
    end
  end

  // A new result wins over a same-edge handshake; overrun only when it clobbers an unread one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_last) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_cnt_pack;
        r_overrun <= r_m_valid & ~m_ready;
      end else if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_zcr_multi.sv
// Bench for zcr_multi: two instances (HYST=0 and HYST=10) on shared stimulus,
// checked every cycle against a sign-history model plus hand-computed epoch results.
module tb_zcr_multi;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int L  = 8;
  localparam int CW = $clog2(L + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            s_valid = 1'b0;
  logic            m_ready = 1'b0;
  logic [N*DW-1:0] s_data = '0;
  logic            mv0, ov0, mv1, ov1;
  logic [N*CW-1:0] md0, md1;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  zcr_multi #(.N_CH(N), .DATA_W(DW), .EPOCH_LENGTH(L), .HYST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_data(s_data),
    .m_valid(mv0), .m_ready(m_ready), .m_data(md0), .overrun(ov0));

  zcr_multi #(.N_CH(N), .DATA_W(DW), .EPOCH_LENGTH(L), .HYST(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_data(s_data),
    .m_valid(mv1), .m_ready(m_ready), .m_data(md1), .overrun(ov1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remember the sign of the last out-of-band sample; a crossing is a sign flip.
  int            hy [2] = '{0, 10};
  int            last_sg [2][N];
  int            cnt [2][N];
  int            idx;
  bit            e_mv [2];
  bit            e_ov [2];
  bit [N*CW-1:0] e_md [2];
  bit            m_done;
  int            m_x, m_sg;
  logic signed [DW-1:0] m_xs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx = 0;
      for (int d = 0; d < 2; d++) begin
        e_mv[d] = 1'b0; e_ov[d] = 1'b0; e_md[d] = '0;
        for (int c = 0; c < N; c++) begin last_sg[d][c] = 0; cnt[d][c] = 0; end
      end
    end else begin
      m_done = en && s_valid && (idx == L - 1);
      for (int d = 0; d < 2; d++) begin
        if (!en) begin
          for (int c = 0; c < N; c++) begin last_sg[d][c] = 0; cnt[d][c] = 0; end
        end else if (s_valid) begin
          for (int c = 0; c < N; c++) begin
            m_xs = s_data[c*DW +: DW];
            m_x  = m_xs;
            m_sg = (m_x > hy[d]) ? 1 : ((m_x < -hy[d]) ? -1 : 0);
            if (m_sg != 0 && last_sg[d][c] != 0 && m_sg != last_sg[d][c]) cnt[d][c]++;
            if (m_sg != 0) last_sg[d][c] = m_sg;
          end
        end
        if (m_done) begin
          e_ov[d] = e_mv[d] && !m_ready;
          for (int c = 0; c < N; c++) begin
            e_md[d][c*CW +: CW] = CW'(cnt[d][c]);
            cnt[d][c] = 0;
          end
          e_mv[d] = 1'b1;
        end else begin
          e_ov[d] = 1'b0;
          if (e_mv[d] && m_ready) e_mv[d] = 1'b0;
        end
      end
      if (!en) idx = 0;
      else if (s_valid) idx = (idx == L - 1) ? 0 : idx + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("d0_valid",   mv0, e_mv[0]);
      chk("d0_overrun", ov0, e_ov[0]);
      chk("d0_data",    md0, e_md[0]);
      chk("d1_valid",   mv1, e_mv[1]);
      chk("d1_overrun", ov1, e_ov[1]);
      chk("d1_data",    md1, e_md[1]);
    end
  end

  task automatic step(input bit v, input bit e, input int a0, input int a1,
                      input int a2, input int a3, input bit rdy);
    s_valid = v;
    en      = e;
    s_data  = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    m_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  int t2 [8] = '{20, 5, -5, 3, -15, -2, 11, 9};
  int r0, r1, r2, r3;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",   mv0, 1'b0);
    chk("rst_data",    md0, '0);
    chk("rst_overrun", ov0, 1'b0);
    cmp_on = 1'b1;
    rst_n  = 1'b1;

    // basic pattern, all four channel behaviours
    for (int i = 0; i < L; i++) step(1, 1, (i % 2 == 0) ? 5 : -5, 3, 0, (i == 0) ? -1 : 1, 1);
    chk("t1_valid",   mv0, 1'b1);
    chk("t1_d0_data", md0, 16'h1007);
    chk("t1_d1_data", md1, 16'h0000);

    // dead-band samples ignored on the HYST=10 instance
    for (int i = 0; i < L; i++) step(1, 1, t2[i], 0, 0, 0, 1);
    chk("t2_d0_data", md0, 16'h0005);
    chk("t2_d1_data", md1, 16'h0002);

    // state carries into the next epoch: crossing on sample 0 counts
    for (int i = 0; i < L; i++) step(1, 1, -20, 0, 0, 0, 1);
    chk("t3_d0_data", md0, 16'h0001);
    chk("t3_d1_data", md1, 16'h0001);
    step(0, 1, 0, 0, 0, 0, 1);

    // two unread epochs -> overrun on the second
    for (int i = 0; i < L; i++) step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < L; i++) step(1, 1, (i % 2) ? -5 : 5, (i % 2) ? -50 : 50, 0, 0, 0);
    chk("t4_overrun", ov0, 1'b1);
    chk("t4_d0_data", md0, 16'h0078);
    chk("t4_d1_data", md1, 16'h0070);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("t4_drained", mv0, 1'b0);
    for (int i = 0; i < L; i++) step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < L; i++) step(1, 1, 0, 0, 0, (i % 2) ? 50 : -50, (i == L - 1));
    chk("t4_same_edge_valid",   mv0, 1'b1);
    chk("t4_same_edge_overrun", ov0, 1'b0);
    chk("t4_same_edge_d0",      md0, 16'h8000);
    chk("t4_same_edge_d1",      md1, 16'h7000);
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);

    // random stalls and random ready
    for (int i = 0; i < 60; i++) begin
      r0 = int'($urandom_range(80)) - 40;
      r1 = int'($urandom_range(80)) - 40;
      r2 = int'($urandom_range(80)) - 40;
      r3 = int'($urandom_range(80)) - 40;
      step(bit'($urandom_range(1)), 1, r0, r1, r2, r3, bit'($urandom_range(1)));
    end
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);

    // soft clear mid-epoch discards the partial epoch and the channel state
    for (int i = 0; i < 5; i++) step(1, 1, 5, 0, 50, 0, 1);
    step(1, 0, 5, 0, 50, 0, 1);
    for (int i = 0; i < L; i++) step(1, 1, (i % 2) ? 5 : -5, 0, (i % 2) ? 50 : -50, 0, 1);
    chk("t6_valid",   mv0, 1'b1);
    chk("t6_d0_data", md0, 16'h0707);
    chk("t6_d1_data", md1, 16'h0700);
    step(0, 1, 0, 0, 0, 0, 1);

    // async reset while a result is pending
    for (int i = 0; i < L; i++) step(1, 1, (i % 2) ? -30 : 30, 0, 0, 0, 0);
    chk("t6_pending",      mv0, 1'b1);
    chk("t6_pending_data", md0, 16'h0007);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid0", mv0, 1'b0);
    chk("rst_async_data0",  md0, '0);
    chk("rst_async_valid1", mv1, 1'b0);
    chk("rst_async_data1",  md1, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
